uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART byte transmitter between `NUM_REQ` requesters. Each requester hands over one byte at a time into a private holding slot with a pending flag. The arbiter picks the next pending slot, launches it on the transmitter, and waits for completion before clearing the slot. A watchdog drops a byte whose completion never arrives and raises a sticky error.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `DATA_W`, default 8: byte width.
- `DONE_TIMEOUT`, default 16'd50000: cycles allowed in WAIT before the byte is abandoned.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester offer of a byte.
- `req_data`  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  slot i empty; byte accepted when valid&&ready.
- `tx_start`  out  1  one-cycle launch pulse to transmitter.
- `tx_data`  out  DATA_W  byte to transmit; stable from LAUNCH through WAIT.
- `tx_busy`  in  1  transmitter currently shifting.
- `tx_done`  in  1  one-cycle pulse: transmitter finished the byte.
- `grant_id`  out  $clog2(NUM_REQ)  slot currently owned by transmitter.
- `active`  out  1  high in LAUNCH and WAIT.
- `timeout_err`  out  1  sticky; set on watchdog expiry, cleared only by reset.

## Operation
- Slot i: DATA_W holding register plus pending flag. Accept (req_valid[i] && !pending[i]) loads the register and sets pending. `req_ready[i] = !pending[i]` (combinational from flag).
- Flag update priority: reset > clear > set > hold. A clear and a set in the same cycle leaves the flag 0.
- FSM states:
  - IDLE → LAUNCH: when any pending bit is set. Register `grant_id` as the first pending slot at or after `rr_ptr`, searching upward with wrap.
  - LAUNCH: `tx_start` = 1 only when `tx_busy` = 0. Stay while `tx_busy` = 1. Go to WAIT on the cycle `tx_start` is high.
  - WAIT → IDLE: on `tx_done`. Clear pending[grant_id]. `rr_ptr` ← grant_id+1, modulo NUM_REQ.
  - WAIT → IDLE: on watchdog count reaching DONE_TIMEOUT-1 without `tx_done`. Clear the slot, set `timeout_err`, update `rr_ptr` the same way.
- Watchdog: counter zeroed on WAIT entry, increments each WAIT cycle, never runs outside WAIT.
- `tx_done` outside WAIT is ignored.
- `tx_data` is a combinational mux of slot[grant_id]. The slot cannot change while pending, so the value is stable.
- Reset values: every pending flag 0, so `req_ready` is all 1s. Also FSM=IDLE, `rr_ptr`=0, `grant_id`=0, `tx_start`=0, `active`=0, `timeout_err`=0, watchdog=0. Holding registers are don't-care.
- Reset mid-transfer: the held byte is discarded. No `tx_start` is issued in the cycle after reset.

## Timing
- Accept at edge n. Pending is visible at n+1, IDLE decides at n+1, LAUNCH starts at n+2. `tx_start` is high during cycle n+2 if `tx_busy` = 0.
- Minimum byte-to-byte overhead: `tx_done` cycle, then one IDLE cycle, then LAUNCH.
- A slot freed by `tx_done` at edge m shows `req_ready` high from m+1. The earliest refill is accepted at edge m+1.
- Fairness: with all slots continuously pending, grant order is 0,1,2,3,0,… Worst-case wait is NUM_REQ-1 transfers.

## Structure
- Package `uart_arb_pkg`: FSM state encoding (IDLE, LAUNCH, WAIT), default DATA_W, and the watchdog counter width (16 bits).
- Sub-module `req_slot`: holding register plus the clear-dominant pending flag (inputs load, clear; outputs pending, data). Instantiated NUM_REQ times.
- Arbiter FSM, rotating priority search and watchdog live in the top.

## Test plan
- Reset, then a single request: slot 2 offers 0xA5 at edge 0. `tx_start` with `tx_data`=0xA5 and `grant_id`=2 at cycle 2. `tx_done` at cycle 10 gives `req_ready[2]`=1 at cycle 11.
- All four slots load at the same edge (0x10..0x13) with `rr_ptr`=0. Launches come in order 0,1,2,3. After `rr_ptr` reaches 3, a new request on slot 0 and slot 3 is served slot 0 first.
- `tx_busy` held high for 5 cycles on LAUNCH entry. `tx_start` stays low for those 5 cycles and pulses exactly once afterwards.
- `tx_done` arrives in the same cycle as `req_valid` on the granted slot. The byte is not accepted. The slot ends empty and accepts on the next cycle.
- With DONE_TIMEOUT=8 and no `tx_done`: WAIT exits after 8 cycles, `timeout_err`=1, the slot is cleared, and the next pending slot launches.
- Reset asserted mid-WAIT with 3 slots pending. Next cycle: all `req_ready`=1, `active`=0, `timeout_err`=0, no `tx_start`.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and widths.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } arb_state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int WDOG_W         = 16;

endpackage

// File: rtl/uart_tx_arbiter_req_slot.sv
// One requester holding slot: a byte register plus a clear-dominant pending flag.
module req_slot
  import uart_arb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic              pending,
  output logic [DATA_W-1:0] data
);

  logic accept;

  assign accept = load && !pending;

  // Clear wins over a same-cycle load so a finishing slot always ends empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (accept) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !clear) begin
      data <= din;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ requesters,
// with a completion watchdog that drops a stuck byte and raises a sticky error.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int                NUM_REQ      = 4,
  parameter int                DATA_W       = DEFAULT_DATA_W,
  parameter logic [WDOG_W-1:0] DONE_TIMEOUT = 16'd50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [WDOG_W-1:0] WDOG_LAST = DONE_TIMEOUT - WDOG_W'(1);

  arb_state_t        state;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     pick;
  logic [GW-1:0]     next_ptr;
  logic [WDOG_W-1:0] wdog;
  logic              wdog_expire;
  logic              finish;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] slot_clear;
  logic [DATA_W-1:0]  slot_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    req_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk    (clk),
      .reset  (reset),
      .load   (req_valid[i]),
      .clear  (slot_clear[i]),
      .din    (req_data[i*DATA_W +: DATA_W]),
      .pending(pending[i]),
      .data   (slot_data[i])
    );
  end

  assign req_ready   = ~pending;
  assign tx_start    = (state == ST_LAUNCH) && !tx_busy;
  assign tx_data     = slot_data[grant_id];
  assign wdog_expire = (wdog == WDOG_LAST);
  assign finish      = (state == ST_WAIT) && (tx_done || wdog_expire);
  assign next_ptr    = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

  always_comb begin
    slot_clear = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_clear[i] = finish && (grant_id == GW'(i));
    end
  end

  // Walk downward from the farthest offset so the closest pending slot at or after rr_ptr wins.
  always_comb begin
    int idx;
    idx  = 0;
    pick = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (pending[idx]) begin
        pick = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant_id    <= '0;
      rr_ptr      <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
      wdog        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            grant_id <= pick;
            active   <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (!tx_busy) begin
            wdog  <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A real completion on the last watchdog cycle still counts as success.
          if (tx_done || wdog_expire) begin
            if (!tx_done) begin
              timeout_err <= 1'b1;
            end
            rr_ptr <= next_ptr;
            active <= 1'b0;
            wdog   <= '0;
            state  <= ST_IDLE;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        default: begin
          active <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a single-transfer vector table plus
// sequences for rotation, busy stall, done/refill overlap, watchdog and reset.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  int total;
  int bad;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [3:0]  ready;
    logic        start;
    logic        act;
    logic [1:0]  grant;
    logic        chk_data;
    logic [7:0]  txd;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .DONE_TIMEOUT(16'd8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .grant_id   (grant_id),
    .active     (active),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [31:0] data,
                              input logic busy, input logic done, input logic [3:0] ready,
                              input logic start, input logic act, input logic [1:0] grant,
                              input logic chk_data, input logic [7:0] txd, input logic err);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.busy = busy; v.done = done;
    v.ready = ready; v.start = start; v.act = act; v.grant = grant;
    v.chk_data = chk_data; v.txd = txd; v.err = err;
    return v;
  endfunction

  // Drive one cycle's inputs just after the edge, then return mid-cycle for sampling.
  task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic [31:0] data,
                               input logic busy, input logic done);
    @(posedge clk);
    #1;
    reset     = rst;
    req_valid = valid;
    req_data  = data;
    tx_busy   = busy;
    tx_done   = done;
    #4;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 4'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 4'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("rst_ready", req_ready, 4'hF);
    checkOutput("rst_start", tx_start, 1'b0);
    checkOutput("rst_active", active, 1'b0);
    checkOutput("rst_grant", grant_id, 2'd0);
    checkOutput("rst_err", timeout_err, 1'b0);
  endtask

  task automatic waitLaunch(input logic [1:0] exp_grant, input logic [7:0] exp_data, input int exp_lat);
    int  n;
    bit  seen;
    n    = 0;
    seen = 0;
    while (!seen && n < 20) begin
      idle(1);
      n++;
      if (tx_start === 1'b1) seen = 1;
    end
    checkOutput("launch_seen", seen, 1);
    if (seen) begin
      checkOutput("launch_latency", n, exp_lat);
      checkOutput("launch_grant", grant_id, exp_grant);
      checkOutput("launch_data", tx_data, exp_data);
    end
  endtask

  task automatic serveOne(input logic [1:0] exp_grant, input logic [7:0] exp_data,
                          input int exp_lat, input int done_after);
    waitLaunch(exp_grant, exp_data, exp_lat);
    idle(done_after);
    applyStimulus(1'b0, 4'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] stuck");
  end

  initial begin
    int starts;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;

    vecs[0]  = mk(0, 4'b0100, 32'h44A52211, 0, 0, 4'hF, 0, 0, 2'd0, 0, 8'h00, 0);
    vecs[1]  = mk(0, 4'b0000, 32'h44A52211, 0, 0, 4'hB, 0, 0, 2'd0, 0, 8'h00, 0);
    vecs[2]  = mk(0, 4'b0000, 32'h44A52211, 0, 0, 4'hB, 1, 1, 2'd2, 1, 8'hA5, 0);
    for (int i = 3; i <= 9; i++)
      vecs[i] = mk(0, 4'b0000, 32'h44A52211, 0, 0, 4'hB, 0, 1, 2'd2, 1, 8'hA5, 0);
    vecs[10] = mk(0, 4'b0000, 32'h44A52211, 0, 1, 4'hB, 0, 1, 2'd2, 1, 8'hA5, 0);
    vecs[11] = mk(0, 4'b0000, 32'h44A52211, 0, 0, 4'hF, 0, 0, 2'd2, 0, 8'h00, 0);

    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].busy, vecs[i].done);
      checkOutput($sformatf("vec%0d_ready", i), req_ready, vecs[i].ready);
      checkOutput($sformatf("vec%0d_start", i), tx_start, vecs[i].start);
      checkOutput($sformatf("vec%0d_active", i), active, vecs[i].act);
      checkOutput($sformatf("vec%0d_grant", i), grant_id, vecs[i].grant);
      checkOutput($sformatf("vec%0d_err", i), timeout_err, vecs[i].err);
      if (vecs[i].chk_data) checkOutput($sformatf("vec%0d_data", i), tx_data, vecs[i].txd);
    end

    // Rotation from rr_ptr=0, then wrap back to slot 0 ahead of slot 3.
    doReset();
    applyStimulus(1'b0, 4'b1111, 32'h13121110, 1'b0, 1'b0);
    serveOne(2'd0, 8'h10, 2, 2);
    serveOne(2'd1, 8'h11, 2, 0);
    serveOne(2'd2, 8'h12, 2, 3);
    serveOne(2'd3, 8'h13, 2, 1);
    applyStimulus(1'b0, 4'b1001, 32'h23000020, 1'b0, 1'b0);
    serveOne(2'd0, 8'h20, 2, 1);
    serveOne(2'd3, 8'h23, 2, 1);

    // Transmitter busy for 5 cycles on LAUNCH entry.
    starts = 0;
    applyStimulus(1'b0, 4'b0010, 32'h00005C00, 1'b0, 1'b0);
    idle(1);
    checkOutput("busy_idle_active", active, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'b0, 32'h0, 1'b1, 1'b0);
      if (tx_start === 1'b1) starts++;
      checkOutput($sformatf("busy_hold%0d_start", k), tx_start, 1'b0);
      checkOutput($sformatf("busy_hold%0d_active", k), active, 1'b1);
    end
    applyStimulus(1'b0, 4'b0, 32'h0, 1'b0, 1'b0);
    if (tx_start === 1'b1) starts++;
    checkOutput("busy_release_start", tx_start, 1'b1);
    checkOutput("busy_release_grant", grant_id, 2'd1);
    checkOutput("busy_release_data", tx_data, 8'h5C);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'b0, 32'h0, 1'b1, 1'b0);
      if (tx_start === 1'b1) starts++;
    end
    checkOutput("busy_start_pulses", starts, 1);

    // tx_done together with a new offer on the granted slot.
    applyStimulus(1'b0, 4'b0010, 32'h00007700, 1'b1, 1'b1);
    checkOutput("overlap_ready_busy", req_ready[1], 1'b0);
    applyStimulus(1'b0, 4'b0010, 32'h00008800, 1'b0, 1'b0);
    checkOutput("overlap_ready_free", req_ready[1], 1'b1);
    checkOutput("overlap_active", active, 1'b0);
    serveOne(2'd1, 8'h88, 2, 0);

    // Watchdog: rr_ptr=2, slot 2 never completes, slot 0 follows.
    applyStimulus(1'b0, 4'b0101, 32'h00320031, 1'b0, 1'b0);
    waitLaunch(2'd2, 8'h32, 2);
    for (int k = 0; k < 8; k++) begin
      idle(1);
      checkOutput($sformatf("wd_wait%0d_active", k), active, 1'b1);
      checkOutput($sformatf("wd_wait%0d_err", k), timeout_err, 1'b0);
    end
    idle(1);
    checkOutput("wd_exit_active", active, 1'b0);
    checkOutput("wd_exit_err", timeout_err, 1'b1);
    checkOutput("wd_exit_ready", req_ready, 4'b1110);
    serveOne(2'd0, 8'h31, 1, 0);
    idle(1);
    checkOutput("wd_err_sticky", timeout_err, 1'b1);

    // Reset during WAIT with three slots pending (rr_ptr=1).
    applyStimulus(1'b0, 4'b0111, 32'h00424140, 1'b0, 1'b0);
    waitLaunch(2'd1, 8'h41, 2);
    idle(2);
    checkOutput("midrst_pre_ready", req_ready, 4'b1000);
    applyStimulus(1'b1, 4'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("midrst_during_active", active, 1'b1);
    applyStimulus(1'b0, 4'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("midrst_ready", req_ready, 4'hF);
    checkOutput("midrst_active", active, 1'b0);
    checkOutput("midrst_err", timeout_err, 1'b0);
    checkOutput("midrst_start", tx_start, 1'b0);
    idle(1);
    checkOutput("midrst_start_next", tx_start, 1'b0);
    checkOutput("midrst_active_next", active, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
